// File: rtl/cmp_window_tally.sv
// Tallies WINDOW comparator results (Ls/Gr/Eq) into per-class counts and a
// majority verdict, then holds the summary behind a valid/ready handshake.
module cmp_window_tally #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             Ls,
  input  logic             Gr,
  input  logic             Eq,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [CNT_W-1:0] ls_cnt,
  output logic [CNT_W-1:0] gr_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [1:0]       verdict,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] smp_cnt;
  logic             accept, last;
  logic             ls_only, gr_only, eq_only, one_hot;
  logic [CNT_W-1:0] ls_nx, gr_nx, eq_nx;

  function automatic logic [1:0] majority(input logic [CNT_W-1:0] l,
                                          input logic [CNT_W-1:0] g,
                                          input logic [CNT_W-1:0] e);
    if (l > g && l > e)      return 2'b01;
    else if (g > l && g > e) return 2'b10;
    else if (e > l && e > g) return 2'b11;
    else                     return 2'b00;
  endfunction

  assign ls_only = Ls & ~Gr & ~Eq;
  assign gr_only = ~Ls & Gr & ~Eq;
  assign eq_only = ~Ls & ~Gr & Eq;
  assign one_hot = ls_only | gr_only | eq_only;

  assign accept  = (state == ACCUM) && in_valid;
  assign last    = accept && (smp_cnt == WIN_LAST);

  // Counts including the current sample, so the verdict taken on the final
  // edge already sees the last one.
  assign ls_nx = ls_cnt + CNT_W'(ls_only);
  assign gr_nx = gr_cnt + CNT_W'(gr_only);
  assign eq_nx = eq_cnt + CNT_W'(eq_only);

  assign busy      = (state == ACCUM);
  assign out_valid = (state == REPORT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = ACCUM;
      ACCUM:   if (last)      state_nx = REPORT;
      REPORT:  if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt <= '0;
      ls_cnt  <= '0;
      gr_cnt  <= '0;
      eq_cnt  <= '0;
      verdict <= 2'b00;
      err     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        smp_cnt <= '0;
        ls_cnt  <= '0;
        gr_cnt  <= '0;
        eq_cnt  <= '0;
        verdict <= 2'b00;
        err     <= 1'b0;
      end else if (accept) begin
        smp_cnt <= smp_cnt + 1'b1;
        ls_cnt  <= ls_nx;
        gr_cnt  <= gr_nx;
        eq_cnt  <= eq_nx;
        if (!one_hot) err <= 1'b1;
        if (last) verdict <= majority(ls_nx, gr_nx, eq_nx);
      end
    end
  end

endmodule

// File: tb/tb_cmp_window_tally.sv
// Directed and randomized checks of cmp_window_tally against a count-based
// reference model that follows the window/verdict rules with plain integers.
module tb_cmp_window_tally;

  localparam int WINDOW = 8;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, Ls, Gr, Eq, out_ready;
  logic             busy, out_valid, err;
  logic [CNT_W-1:0] ls_cnt, gr_cnt, eq_cnt;
  logic [1:0]       verdict;

  cmp_window_tally #(.WINDOW(WINDOW), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .Ls(Ls), .Gr(Gr), .Eq(Eq), .out_ready(out_ready),
    .busy(busy), .out_valid(out_valid),
    .ls_cnt(ls_cnt), .gr_cnt(gr_cnt), .eq_cnt(eq_cnt),
    .verdict(verdict), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=idle, 1=collecting, 2=reporting.
  int m_phase, m_n, m_ls, m_gr, m_eq, m_verdict;
  bit m_err;

  function automatic int majority_of(int l, int g, int e);
    if (l > g && l > e) return 1;
    if (g > l && g > e) return 2;
    if (e > l && e > g) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_ls = 0; m_gr = 0; m_eq = 0;
    m_verdict = 0; m_err = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_busy"},    32'(busy),      32'(m_phase == 1));
    check({tag, "_valid"},   32'(out_valid), 32'(m_phase == 2));
    check({tag, "_ls"},      32'(ls_cnt),    32'(m_ls));
    check({tag, "_gr"},      32'(gr_cnt),    32'(m_gr));
    check({tag, "_eq"},      32'(eq_cnt),    32'(m_eq));
    check({tag, "_err"},     32'(err),       32'(m_err));
    check({tag, "_verdict"}, 32'(verdict),   32'(m_verdict));
  endtask

  // Apply the current inputs for one clock, advancing the model the same edge.
  task automatic cycle();
    int ones;
    ones = int'(Ls) + int'(Gr) + int'(Eq);
    if (m_phase == 0 && start) begin
      m_phase = 1; m_n = 0; m_ls = 0; m_gr = 0; m_eq = 0;
      m_err = 0; m_verdict = 0;
    end else if (m_phase == 1 && in_valid) begin
      m_n++;
      if (ones == 1) begin
        if (Ls) m_ls++;
        if (Gr) m_gr++;
        if (Eq) m_eq++;
      end else begin
        m_err = 1;
      end
      if (m_n == WINDOW) begin
        m_verdict = majority_of(m_ls, m_gr, m_eq);
        m_phase   = 2;
      end
    end else if (m_phase == 2 && out_ready) begin
      m_phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start = 0; in_valid = 0; Ls = 0; Gr = 0; Eq = 0; out_ready = 0;
  endtask

  task automatic samp(input bit l, input bit g, input bit e, input string tag);
    in_valid = 1; Ls = l; Gr = g; Eq = e;
    cycle();
    in_valid = 0; Ls = 0; Gr = 0; Eq = 0;
    check_all(tag);
  endtask

  task automatic do_start(input string tag);
    start = 1;
    cycle();
    start = 0;
    check_all(tag);
  endtask

  task automatic accept_report(input string tag);
    out_ready = 1;
    cycle();
    out_ready = 0;
    check_all(tag);
  endtask

  initial begin
    int r, guard;
    quiet();
    rst = 1;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 0;
    cycle();
    check_all("idle_after_reset");

    // 1: 5 Ls, 2 Gr, 1 Eq -> less majority
    do_start("t1_start");
    for (int i = 0; i < 5; i++) samp(1, 0, 0, "t1_ls");
    for (int i = 0; i < 2; i++) samp(0, 1, 0, "t1_gr");
    samp(0, 0, 1, "t1_last");
    accept_report("t1_accept");
    cycle();
    check_all("t1_idle_hold");

    // 2: 4 Gr, gap of 3 idle-valid cycles, 4 Eq -> tie
    do_start("t2_start");
    for (int i = 0; i < 4; i++) samp(0, 1, 0, "t2_gr");
    for (int i = 0; i < 3; i++) begin cycle(); check_all("t2_gap"); end
    for (int i = 0; i < 4; i++) samp(0, 0, 1, "t2_eq");
    accept_report("t2_accept");

    // 3: 7 Eq plus one Ls+Gr -> equal majority, err set; next start clears err
    do_start("t3_start");
    for (int i = 0; i < 3; i++) samp(0, 0, 1, "t3_eq");
    samp(1, 1, 0, "t3_bad");
    for (int i = 0; i < 4; i++) samp(0, 0, 1, "t3_eq");

    // 4: report held without out_ready, start pulsed and ignored
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      cycle();
      check_all("t4_hold");
    end
    start = 0;
    accept_report("t4_accept");
    do_start("t3_err_clear");
    for (int i = 0; i < WINDOW; i++) samp(0, 0, 0, "t3b_none");
    accept_report("t3b_accept");

    // 5: reset mid-window, then 8 Gr
    do_start("t5_start");
    for (int i = 0; i < 3; i++) samp(1, 0, 0, "t5_ls");
    rst = 1;
    #1;
    model_reset();
    check_all("t5_async_rst");
    @(posedge clk); #1;
    rst = 0;
    do_start("t5_restart");
    for (int i = 0; i < WINDOW; i++) samp(0, 1, 0, "t5_gr");
    accept_report("t5_accept");

    // 6: start and a valid sample in the same idle cycle; that sample is dropped
    start = 1; in_valid = 1; Ls = 1;
    cycle();
    quiet();
    check_all("t6_start");
    for (int i = 0; i < WINDOW; i++) samp(1, 0, 0, "t6_ls");
    accept_report("t6_accept");

    // Randomized windows: gaps, malformed flags, stray start/out_ready, slow consumer
    for (int w = 0; w < 16; w++) begin
      do_start("rnd_start");
      guard = 0;
      while (m_phase == 1 && guard < 200) begin
        guard++;
        start     = ($urandom % 3) == 0;
        out_ready = ($urandom % 2) == 0;
        in_valid  = ($urandom % 4) != 0;
        r = int'($urandom % 16);
        if (r < 4)       begin Ls = 1; Gr = 0; Eq = 0; end
        else if (r < 8)  begin Ls = 0; Gr = 1; Eq = 0; end
        else if (r < 12) begin Ls = 0; Gr = 0; Eq = 1; end
        else begin r = int'($urandom % 8); Ls = r[0]; Gr = r[1]; Eq = r[2]; end
        cycle();
        check_all("rnd_accum");
      end
      quiet();
      for (int d = 0; d < int'($urandom % 4); d++) begin
        start = ($urandom % 2) == 0;
        cycle();
        start = 0;
        check_all("rnd_report_wait");
      end
      accept_report("rnd_accept");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
